// File: rtl/con3_pkg.sv
// con3_pkg: shared definitions for the CON3 motion controller.
//   ANGLE_W          width of every angle value
//   DEF_STEP         default maximum angle change per frame
//   DEF_HOLD_FRAMES  default settle time in frames
//   state_t          controller state encoding
package con3_pkg;

    localparam int ANGLE_W         = 8;
    localparam int DEF_STEP        = 4;
    localparam int DEF_HOLD_FRAMES = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/con3_rr_arbiter.sv
// con3_rr_arbiter: combinational round-robin pick.
//   req      in   N   pending requests
//   rr_ptr   in   PW  index with highest priority this round
//   winner   out  N   one-hot winner (zero when no request)
//   any_req  out  1   at least one request pending
module con3_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic          any_req
);

    logic found;

    // Search rr_ptr..N-1 first, then wrap to 0..rr_ptr-1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i >= int'(rr_ptr)) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i < int'(rr_ptr)) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/con3_motion_ctrl.sv
// con3_motion_ctrl: owns the Pmod CON3 angle input. Arbitrates angle
// requests round-robin, slews the angle toward the granted target by at
// most STEP per PWM frame, then holds for HOLD_FRAMES frames.
//   clk, rst     clock; asynchronous active-high reset
//   frame_tick   one-cycle pulse per servo PWM frame
//   req          level request per requester, held until granted
//   req_angle    target angle per requester, slice i = [8i+7:8i]
//   stop         pulse; abort the move at the present angle
//   grant        one-hot, one-cycle pulse naming the accepted requester
//   angle        registered angle to the CON3 interface
//   target       currently latched target
//   busy         high in MOVE or SETTLE
//   at_target    angle == target
// Build option: define CON3_LIMIT_EN to clamp the latched target to
// [MIN_ANGLE, MAX_ANGLE] at grant time.
module con3_motion_ctrl
    import con3_pkg::*;
#(
    parameter int                 N           = 2,
    parameter int                 STEP        = DEF_STEP,
    parameter int                 HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter logic [ANGLE_W-1:0] INIT_ANGLE  = 8'd128,
    parameter logic [ANGLE_W-1:0] MIN_ANGLE   = 8'd0,
    parameter logic [ANGLE_W-1:0] MAX_ANGLE   = 8'd255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic [N-1:0]         req,
    input  logic [ANGLE_W*N-1:0] req_angle,
    input  logic                 stop,
    output logic [N-1:0]         grant,
    output logic [ANGLE_W-1:0]   angle,
    output logic [ANGLE_W-1:0]   target,
    output logic                 busy,
    output logic                 at_target
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HW-1:0]      HOLD_LAST = HW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam logic [ANGLE_W-1:0] STEP_A    = ANGLE_W'(STEP);

    state_t              state, state_n;
    logic [PW-1:0]       rr_ptr, win_idx, next_ptr;
    logic [HW-1:0]       hold_cnt;
    logic [N-1:0]        winner;
    logic                any_req;
    logic [ANGLE_W-1:0]  sel_angle, lat_angle, diff, step_angle;
    logic                do_grant, do_step, do_stop;

    con3_rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Winner index and its requested angle.
    always_comb begin
        win_idx   = '0;
        sel_angle = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) begin
                win_idx   = PW'(i);
                sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    assign next_ptr = (int'(win_idx) == N - 1) ? '0 : win_idx + PW'(1);

`ifdef CON3_LIMIT_EN
    always_comb begin
        if (sel_angle < MIN_ANGLE)      lat_angle = MIN_ANGLE;
        else if (sel_angle > MAX_ANGLE) lat_angle = MAX_ANGLE;
        else                            lat_angle = sel_angle;
    end
`else
    assign lat_angle = sel_angle;
`endif

    // Saturating step: never overshoots target, so it can never wrap.
    always_comb begin
        diff = (target > angle) ? target - angle : angle - target;
        if (STEP == 0 || int'(diff) <= STEP) step_angle = target;
        else if (target > angle)             step_angle = angle + STEP_A;
        else                                 step_angle = angle - STEP_A;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (any_req) state_n = MOVE;
            MOVE:   if (stop || at_target)
                        state_n = (HOLD_FRAMES == 0) ? IDLE : SETTLE;
            SETTLE: if (frame_tick && !stop && hold_cnt == HOLD_LAST)
                        state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs and datapath strobes
    always_comb begin
        busy      = (state != IDLE);
        at_target = (angle == target);
        do_grant  = (state == IDLE) && any_req;
        do_stop   = (state == MOVE) && stop;
        // stop beats a coincident tick; no step once on target (exiting)
        do_step   = (state == MOVE) && frame_tick && !stop && !at_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            angle    <= INIT_ANGLE;
            target   <= INIT_ANGLE;
            grant    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            grant <= do_grant ? winner : '0;
            if (do_grant) begin
                target <= lat_angle;
                rr_ptr <= next_ptr;
            end
            if (do_stop) target <= angle;
            if (do_step) angle  <= step_angle;

            // Counter is zero on SETTLE entry; stop restarts the hold.
            if (state != SETTLE || stop) hold_cnt <= '0;
            else if (frame_tick)         hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HW'(1);
        end
    end

endmodule

// File: tb/tb_con3_motion_ctrl.sv
// tb_con3_motion_ctrl: directed bench for con3_motion_ctrl.
// dut  : N=2, STEP=4, HOLD_FRAMES=2, full angle range.
// dut_b: N=2, STEP=0, HOLD_FRAMES=0, limits 20..200 (clamped only when
//        CON3_LIMIT_EN is defined).
module tb_con3_motion_ctrl;

    logic        clk, rst;
    logic        frame_tick, stop;
    logic [1:0]  req, grant;
    logic [15:0] req_angle;
    logic [7:0]  angle, target;
    logic        busy, at_target;

    logic        tick_b, stop_b;
    logic [1:0]  req_b, grant_b;
    logic [15:0] ra_b;
    logic [7:0]  angle_b, target_b;
    logic        busy_b, at_b;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] t;
    } gexp_t;
    gexp_t gq[$];

    logic [7:0] a_m, t_m;   // expected angle / target

    con3_motion_ctrl #(
        .N(2), .STEP(4), .HOLD_FRAMES(2), .INIT_ANGLE(8'd128),
        .MIN_ANGLE(8'd0), .MAX_ANGLE(8'd255)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .req(req),
        .req_angle(req_angle), .stop(stop), .grant(grant), .angle(angle),
        .target(target), .busy(busy), .at_target(at_target)
    );

    con3_motion_ctrl #(
        .N(2), .STEP(0), .HOLD_FRAMES(0), .INIT_ANGLE(8'd128),
        .MIN_ANGLE(8'd20), .MAX_ANGLE(8'd200)
    ) dut_b (
        .clk(clk), .rst(rst), .frame_tick(tick_b), .req(req_b),
        .req_angle(ra_b), .stop(stop_b), .grant(grant_b), .angle(angle_b),
        .target(target_b), .busy(busy_b), .at_target(at_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: test did not finish, observed no end, expected end");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lim(input logic [7:0] a);
`ifdef CON3_LIMIT_EN
        if (a < 8'd20)  return 8'd20;
        if (a > 8'd200) return 8'd200;
`endif
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic post(input logic idx, input logic [7:0] a);
        req_angle[{idx, 3'b000} +: 8] = a;
        req[idx] = 1'b1;
    endtask

    task automatic exp_grant(input logic idx, input logic [7:0] a);
        gq.push_back('{g: (idx ? 2'b10 : 2'b01), t: a});
    endtask

    task automatic wait_grant();
        gexp_t e;
        int    cyc;
        e   = gq.pop_front();
        cyc = 0;
        while (grant == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant", 32'(grant), 32'(e.g));
        chk("target_latch", 32'(target), 32'(e.t));
        t_m = e.t;
        req = req & ~e.g;
        @(negedge clk);
        chk("grant_pulse", 32'(grant), 32'd0);
    endtask

    // Tick until the model reaches target (or max ticks), checking each step.
    task automatic move_check(input int max_ticks);
        int n;
        n = 0;
        while (a_m != t_m && n < max_ticks) begin
            if (t_m > a_m) a_m = (t_m - a_m <= 8'd4) ? t_m : a_m + 8'd4;
            else           a_m = (a_m - t_m <= 8'd4) ? t_m : a_m - 8'd4;
            n++;
            tick();
            chk("angle_step", 32'(angle), 32'(a_m));
        end
    endtask

    // One cycle to leave MOVE, then HOLD_FRAMES=2 ticks of SETTLE.
    task automatic settle_idle();
        @(negedge clk);
        chk("settle_busy0", 32'(busy), 32'd1);
        tick();
        chk("settle_busy1", 32'(busy), 32'd1);
        tick();
        chk("settle_done", 32'(busy), 32'd0);
        chk("settle_at_target", 32'(at_target), 32'd1);
    endtask

    task automatic wait_grant_b(input logic [1:0] g, input logic [7:0] t);
        int cyc;
        cyc = 0;
        while (grant_b == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b_grant", 32'(grant_b), 32'(g));
        chk("b_target", 32'(target_b), 32'(t));
        req_b = 2'b00;
        @(negedge clk);
        chk("b_grant_pulse", 32'(grant_b), 32'd0);
    endtask

    task automatic tick_b_pulse();
        tick_b = 1'b1;
        @(negedge clk);
        tick_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; stop = 1'b0;
        req = 2'b01; req_angle = 16'd0;
        tick_b = 1'b0; stop_b = 1'b0; req_b = 2'b00; ra_b = 16'd0;
        a_m = 8'd128; t_m = 8'd128;

        // Reset state, with a request held during reset
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_angle", 32'(angle), 32'd128);
        chk("rst_target", 32'(target), 32'd128);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_at_target", 32'(at_target), 32'd1);
        req = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        // Single move up 128 -> 140
        post(1'b0, 8'd140); exp_grant(1'b0, 8'd140);
        wait_grant();
        chk("no_move_before_tick", 32'(angle), 32'd128);
        move_check(100);
        settle_idle();

        // Down with partial final step 140 -> 126
        post(1'b1, 8'd126); exp_grant(1'b1, 8'd126);
        wait_grant();
        move_check(100);
        chk("partial_at_target", 32'(at_target), 32'd1);
        settle_idle();

        // Round robin with both requesting
        post(1'b0, 8'd130); post(1'b1, 8'd134);
        exp_grant(1'b0, 8'd130);
        wait_grant();
        move_check(100);
        post(1'b0, 8'd126);              // pending while busy
        settle_idle();
        exp_grant(1'b1, 8'd134);
        wait_grant();
        move_check(100);
        settle_idle();
        exp_grant(1'b0, 8'd126);
        wait_grant();
        move_check(100);
        settle_idle();

        // Edge values: up to 255 without wrap, down to 0
        post(1'b0, 8'd250); exp_grant(1'b0, 8'd250); wait_grant(); move_check(100); settle_idle();
        post(1'b1, 8'd255); exp_grant(1'b1, 8'd255); wait_grant(); move_check(100); settle_idle();
        chk("edge_255", 32'(angle), 32'd255);
        post(1'b0, 8'd3);   exp_grant(1'b0, 8'd3);   wait_grant(); move_check(100); settle_idle();
        post(1'b1, 8'd0);   exp_grant(1'b1, 8'd0);   wait_grant(); move_check(100); settle_idle();
        chk("edge_0", 32'(angle), 32'd0);

        // Stop after three ticks of 0 -> 200
        post(1'b0, 8'd200); exp_grant(1'b0, 8'd200);
        wait_grant();
        move_check(3);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        t_m = a_m;
        chk("stop_target", 32'(target), 32'd12);
        chk("stop_angle", 32'(angle), 32'd12);
        chk("stop_settle", 32'(busy), 32'd1);
        tick();
        chk("stop_hold1", 32'(busy), 32'd1);
        stop = 1'b1; @(negedge clk); stop = 1'b0;   // restart hold
        tick();
        chk("hold_restart", 32'(busy), 32'd1);
        tick();
        chk("hold_done", 32'(busy), 32'd0);

        // Stop coincident with a tick in MOVE
        post(1'b1, 8'd40); exp_grant(1'b1, 8'd40);
        wait_grant();
        move_check(1);
        stop = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        stop = 1'b0; frame_tick = 1'b0;
        t_m = a_m;
        chk("stop_tick_angle", 32'(angle), 32'd16);
        chk("stop_tick_target", 32'(target), 32'd16);
        tick();
        tick();
        chk("stop_tick_idle", 32'(busy), 32'd0);

        // Reset mid-move
        post(1'b0, 8'd100); exp_grant(1'b0, 8'd100);
        wait_grant();
        move_check(1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_angle", 32'(angle), 32'd128);
        chk("midrst_target", 32'(target), 32'd128);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a_m = 8'd128; t_m = 8'd128;
        @(negedge clk);

        // dut_b: STEP=0 jumps, HOLD=0, optional clamp
        ra_b[7:0] = 8'd250; req_b = 2'b01;
        wait_grant_b(2'b01, lim(8'd250));
        chk("b_no_move", 32'(angle_b), 32'd128);
        tick_b_pulse();
        chk("b_jump_hi", 32'(angle_b), 32'(lim(8'd250)));
        @(negedge clk);
        chk("b_idle_hi", 32'(busy_b), 32'd0);

        ra_b[15:8] = 8'd5; req_b = 2'b10;
        wait_grant_b(2'b10, lim(8'd5));
        tick_b_pulse();
        chk("b_jump_lo", 32'(angle_b), 32'(lim(8'd5)));
        @(negedge clk);
        chk("b_idle_lo", 32'(busy_b), 32'd0);

        // Target equal to angle on entry: leaves MOVE without a tick
        ra_b[7:0] = lim(8'd5); req_b = 2'b01;
        wait_grant_b(2'b01, lim(8'd5));
        chk("b_eq_idle", 32'(busy_b), 32'd0);
        chk("b_eq_angle", 32'(angle_b), 32'(lim(8'd5)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/con3_motion_ctrl.md
Name: con3_motion_ctrl

Overview:
- Motion controller that sits in front of the Pmod CON3 servo interface and owns its 8-bit angle input.
- Arbitrates angle requests from N requesters (e.g. UART command path, sweep generator, limit handler) with round-robin priority.
- Slews the servo angle toward the granted target by a bounded step once per PWM frame, then holds the target for a settle time.

Parameters:
- N, 2, number of requesters (1..8).
- STEP, 4, maximum angle change per frame_tick; 0 means jump to target on the first tick.
- HOLD_FRAMES, 10, frame_ticks spent in SETTLE after reaching target (0 = skip SETTLE).
- INIT_ANGLE, 8'd128, angle value at reset.
- MIN_ANGLE, 8'd0, lower clamp (used only with CON3_LIMIT_EN).
- MAX_ANGLE, 8'd255, upper clamp (used only with CON3_LIMIT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per servo PWM frame, from the CON3 interface.
- req  in  N  level request per requester; held high until granted.
- req_angle  in  8*N  target angle per requester; slice i is [8i+7:8i].
- stop  in  1  pulse; abort the current move at the present angle.
- grant  out  N  one-hot, one-cycle pulse marking the accepted requester.
- angle  out  8  registered angle driven to the CON3 interface.
- target  out  8  currently latched target.
- busy  out  1  high in MOVE or SETTLE.
- at_target  out  1  high when angle == target.

Behaviour:
- Reset values: angle=INIT_ANGLE, target=INIT_ANGLE, grant=0, busy=0, at_target=1, state=IDLE, rr_ptr=0, hold counter=0.
- Reset mid-move discards the move; no grant is issued in the reset cycle.

States and transitions:
- IDLE: if any req, grant the first set bit searching from rr_ptr upward with wrap.
  - Latch req_angle[winner] into target, pulse grant for exactly one cycle, set rr_ptr=winner+1 mod N, go to MOVE next cycle.
  - With no req, remain in IDLE.
  - Grant only ever occurs in IDLE.
- MOVE: on each frame_tick, compute d = |target - angle| as 8-bit unsigned with no wrap.
  - If d <= STEP or STEP==0: angle <= target.
  - Otherwise angle <= angle ± STEP toward target. No overshoot, never wraps 255→0.
  - Exit rule (single, unambiguous): when angle==target, go to SETTLE, or to IDLE if HOLD_FRAMES==0. This applies whether equality holds on MOVE entry (target==angle on grant, no tick consumed) or results from a tick update (transition in the cycle after the update).
- SETTLE: count frame_ticks; after HOLD_FRAMES ticks go to IDLE.
- angle changes only on frame_tick in MOVE. Latency from grant to first angle change is the next frame_tick, at least one cycle later.

Stop and simultaneous events:
- stop in MOVE: target <= angle, go to SETTLE (or IDLE if HOLD_FRAMES==0).
- stop in SETTLE: restart the hold counter.
- stop in IDLE: ignored.
- stop together with frame_tick: stop wins and angle is not updated.
- req arriving during MOVE/SETTLE stays pending and is arbitrated on IDLE entry; the first grant can occur in the cycle after the state becomes IDLE.
- Output definitions: busy = (state!=IDLE); at_target = (angle==target), combinational from registers.

Optional Feature:
- Macro: CON3_LIMIT_EN.
- Defined: the latched target is clamped to [MIN_ANGLE, MAX_ANGLE] at grant time, and the target output shows the clamped value. A request outside range is still granted.
- Undefined: target is latched unmodified; MIN_ANGLE and MAX_ANGLE are unused.

Decomposition:
- Shared package con3_pkg:
  - State encoding typedef (IDLE, MOVE, SETTLE).
  - ANGLE_W=8.
  - Default STEP and HOLD_FRAMES constants.
- Sub-module con3_rr_arbiter: N-wide round-robin pick from req and rr_ptr, giving a one-hot winner and any_req. Combinational, instantiated once.

Test Plan:
- Single move up: N=2, INIT=128, STEP=4, HOLD=2; req[0]=1 with angle 140 → grant=01 for 1 cycle; angle 132, 136, 140 on three ticks; busy drops 2 ticks after reaching 140.
- Partial step, down: target 126 from 128, STEP=4 → one tick gives angle=126 with no overshoot; at_target=1.
- Round-robin: req=11 held in IDLE → grant 01 first; after the move completes, grant 10; then 01 again if both are still asserted.
- Stop: moving 0→200 at STEP=4; stop after 3 ticks (angle=12) → target=12, angle stays 12; a stop coincident with a tick keeps angle=12.
- Edge values: target 255 from 250, STEP=10 → angle=255 with no wrap; target 0 from 3 → angle=0; STEP=0 → jump to target on the first tick.
- Reset mid-MOVE → angle=target=128, busy=0, grant=0. With CON3_LIMIT_EN, MIN=20 and MAX=200: request 250 → target=200; request 5 → target=20.
